// File: rtl/dcmac_rx_4seg.sv
// DCMAC 4-segment RX realigner: repacks segments so each packet starts in stream 0,
// buffered through a small show-ahead beat FIFO that drains one beat per cycle.
module dcmac_rx_4seg #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [127:0]     rx_axis_tdata0,
  input  logic [127:0]     rx_axis_tdata1,
  input  logic [127:0]     rx_axis_tdata2,
  input  logic [127:0]     rx_axis_tdata3,
  input  logic             rx_axis_tuser_ena0,
  input  logic             rx_axis_tuser_ena1,
  input  logic             rx_axis_tuser_ena2,
  input  logic             rx_axis_tuser_ena3,
  input  logic             rx_axis_tuser_sop0,
  input  logic             rx_axis_tuser_sop1,
  input  logic             rx_axis_tuser_sop2,
  input  logic             rx_axis_tuser_sop3,
  input  logic             rx_axis_tuser_eop0,
  input  logic             rx_axis_tuser_eop1,
  input  logic             rx_axis_tuser_eop2,
  input  logic             rx_axis_tuser_eop3,
  input  logic [3:0]       rx_axis_tuser_mty0,
  input  logic [3:0]       rx_axis_tuser_mty1,
  input  logic [3:0]       rx_axis_tuser_mty2,
  input  logic [3:0]       rx_axis_tuser_mty3,
  input  logic             rx_axis_tuser_err0,
  input  logic             rx_axis_tuser_err1,
  input  logic             rx_axis_tuser_err2,
  input  logic             rx_axis_tuser_err3,
  input  logic             rx_axis_valid,
  output logic [127:0]     axis0_out_tdata,
  output logic [127:0]     axis1_out_tdata,
  output logic [127:0]     axis2_out_tdata,
  output logic [127:0]     axis3_out_tdata,
  output logic [5:0]       axis0_out_tuser,
  output logic [5:0]       axis1_out_tuser,
  output logic [5:0]       axis2_out_tuser,
  output logic [5:0]       axis3_out_tuser,
  output logic             axis0_out_tlast,
  output logic             axis1_out_tlast,
  output logic             axis2_out_tlast,
  output logic             axis3_out_tlast,
  output logic             axis0_out_tvalid,
  output logic             axis1_out_tvalid,
  output logic             axis2_out_tvalid,
  output logic             axis3_out_tvalid,
  output logic [CNT_W-1:0] overflow_count,
  output logic [CNT_W-1:0] protocol_err_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 2;
  localparam int MAXB = 8;

  typedef struct packed {
    logic            last;
    logic [3:0][5:0] user;
    logic [3:0][127:0] data;
  } beat_t;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  logic [3:0][127:0] seg_data_s;
  logic [3:0][3:0]   seg_mty_s;
  logic [3:0]        seg_ena_s, seg_sop_s, seg_eop_s, seg_err_s;

  state_t            state_r, state_s;
  logic [1:0]        fill_r, fill_s;
  logic [2:0][127:0] stage_r;
  logic [3:0][127:0] slot_s;
  beat_t             beats_s [MAXB];
  logic [CW-1:0]     npush_s, perr_s, free_s, accept_s, drop_s, count_r;
  logic              pop_s;
  beat_t             mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  beat_t             out_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  ovf_cnt_r, perr_cnt_r;

  assign seg_data_s = {rx_axis_tdata3, rx_axis_tdata2, rx_axis_tdata1, rx_axis_tdata0};
  assign seg_mty_s  = {rx_axis_tuser_mty3, rx_axis_tuser_mty2, rx_axis_tuser_mty1, rx_axis_tuser_mty0};
  assign seg_ena_s  = {rx_axis_tuser_ena3, rx_axis_tuser_ena2, rx_axis_tuser_ena1, rx_axis_tuser_ena0};
  assign seg_sop_s  = {rx_axis_tuser_sop3, rx_axis_tuser_sop2, rx_axis_tuser_sop1, rx_axis_tuser_sop0};
  assign seg_eop_s  = {rx_axis_tuser_eop3, rx_axis_tuser_eop2, rx_axis_tuser_eop1, rx_axis_tuser_eop0};
  assign seg_err_s  = {rx_axis_tuser_err3, rx_axis_tuser_err2, rx_axis_tuser_err1, rx_axis_tuser_err0};

  // Builds a beat from the first n slots; unused slots are flagged empty and zeroed.
  function automatic beat_t make_beat(input logic [3:0][127:0] sl, input logic [2:0] n,
                                      input logic last, input logic err, input logic [3:0] mty);
    beat_t b;
    b      = '0;
    b.last = last;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n) begin
        b.data[k] = sl[k];
        b.user[k] = {err, 1'b0, (3'(k) + 3'd1 == n) ? mty : 4'd0};
      end else begin
        b.user[k] = {err, 1'b1, 4'd0};
      end
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CW-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) begin
      return '1;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Walk segments 0..3 through the framing FSM, collecting completed beats in order.
  always_comb begin
    state_s = state_r;
    fill_s  = fill_r;
    slot_s  = {128'd0, stage_r};
    npush_s = '0;
    perr_s  = '0;
    for (int b = 0; b < MAXB; b++) begin
      beats_s[b] = '0;
    end
    if (rx_axis_valid) begin
      for (int s = 0; s < 4; s++) begin
        if (seg_ena_s[s]) begin
          if (seg_sop_s[s]) begin
            if (state_s == IN_PKT) begin
              beats_s[npush_s[2:0]] = make_beat(slot_s, {1'b0, fill_s}, 1'b1, 1'b1, 4'd0);
              npush_s = npush_s + CW'(1);
              perr_s  = perr_s + CW'(1);
            end else begin
              perr_s  = perr_s;
            end
            state_s = IN_PKT;
            fill_s  = 2'd0;
          end else if (state_s == IDLE) begin
            perr_s = perr_s + CW'(1);
          end else begin
            perr_s = perr_s;
          end
          if (state_s == IN_PKT) begin
            slot_s[fill_s] = seg_data_s[s];
            if (seg_eop_s[s]) begin
              // A sop+eop segment is a runt packet and is always flagged errored.
              beats_s[npush_s[2:0]] = make_beat(slot_s, {1'b0, fill_s} + 3'd1, 1'b1,
                                                seg_err_s[s] | seg_sop_s[s], seg_mty_s[s]);
              npush_s = npush_s + CW'(1);
              state_s = IDLE;
              fill_s  = 2'd0;
            end else if (fill_s == 2'd3) begin
              beats_s[npush_s[2:0]] = make_beat(slot_s, 3'd4, 1'b0, 1'b0, 4'd0);
              npush_s = npush_s + CW'(1);
              fill_s  = 2'd0;
            end else begin
              fill_s  = fill_s + 2'd1;
            end
          end else begin
            fill_s = fill_s;
          end
        end else begin
          fill_s = fill_s;
        end
      end
    end else begin
      fill_s = fill_r;
    end
  end

  // A pop this cycle frees one slot for the pushes arriving in the same cycle.
  assign pop_s    = (count_r != '0);
  assign free_s   = CW'(FIFO_DEPTH) - count_r + CW'(pop_s);
  assign accept_s = (npush_s < free_s) ? npush_s : free_s;
  assign drop_s   = npush_s - accept_s;

  // FIFO storage: accepted beats land in consecutive entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAXB; i++) begin
      if (CW'(i) < accept_s) begin
        mem_r[wr_ptr_r + AW'(i)] <= beats_s[i];
      end
    end
  end

  // Framing state, FIFO pointers, output register and error counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      fill_r      <= 2'd0;
      stage_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      ovf_cnt_r   <= '0;
      perr_cnt_r  <= '0;
    end else begin
      state_r    <= state_s;
      fill_r     <= fill_s;
      stage_r    <= slot_s[2:0];
      wr_ptr_r   <= wr_ptr_r + accept_s[AW-1:0];
      rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
      count_r    <= count_r + accept_s - CW'(pop_s);
      ovf_cnt_r  <= sat_add(ovf_cnt_r, drop_s);
      perr_cnt_r <= sat_add(perr_cnt_r, perr_s);
      if (pop_s) begin
        out_r       <= mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else begin
        out_r       <= '0;
        out_valid_r <= 1'b0;
      end
    end
  end

  assign axis0_out_tdata    = out_r.data[0];
  assign axis1_out_tdata    = out_r.data[1];
  assign axis2_out_tdata    = out_r.data[2];
  assign axis3_out_tdata    = out_r.data[3];
  assign axis0_out_tuser    = out_r.user[0];
  assign axis1_out_tuser    = out_r.user[1];
  assign axis2_out_tuser    = out_r.user[2];
  assign axis3_out_tuser    = out_r.user[3];
  assign axis0_out_tlast    = out_r.last;
  assign axis1_out_tlast    = out_r.last;
  assign axis2_out_tlast    = out_r.last;
  assign axis3_out_tlast    = out_r.last;
  assign axis0_out_tvalid   = out_valid_r;
  assign axis1_out_tvalid   = out_valid_r;
  assign axis2_out_tvalid   = out_valid_r;
  assign axis3_out_tvalid   = out_valid_r;
  assign overflow_count     = ovf_cnt_r;
  assign protocol_err_count = perr_cnt_r;

endmodule

// File: tb/tb_dcmac_rx_4seg.sv
// Scoreboard bench for dcmac_rx_4seg: a queue-based packet model predicts every output
// beat and the cycle it must appear; a negedge monitor pops and compares.
module tb_dcmac_rx_4seg;
  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int SAT   = (1 << CW) - 1;

  typedef struct packed {
    logic [3:0][127:0] d;
    logic [3:0][5:0]   u;
    logic              l;
    int                c;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] td [4];
  logic         ena [4], sop [4], eop [4], err [4];
  logic [3:0]   mty [4];
  logic         valid;
  logic [127:0] o_d [4];
  logic [5:0]   o_u [4];
  logic         o_l [4], o_v [4];
  logic [CW-1:0] ovf_cnt, perr_cnt;

  dcmac_rx_4seg #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .rx_axis_tdata0(td[0]), .rx_axis_tdata1(td[1]), .rx_axis_tdata2(td[2]), .rx_axis_tdata3(td[3]),
    .rx_axis_tuser_ena0(ena[0]), .rx_axis_tuser_ena1(ena[1]), .rx_axis_tuser_ena2(ena[2]), .rx_axis_tuser_ena3(ena[3]),
    .rx_axis_tuser_sop0(sop[0]), .rx_axis_tuser_sop1(sop[1]), .rx_axis_tuser_sop2(sop[2]), .rx_axis_tuser_sop3(sop[3]),
    .rx_axis_tuser_eop0(eop[0]), .rx_axis_tuser_eop1(eop[1]), .rx_axis_tuser_eop2(eop[2]), .rx_axis_tuser_eop3(eop[3]),
    .rx_axis_tuser_mty0(mty[0]), .rx_axis_tuser_mty1(mty[1]), .rx_axis_tuser_mty2(mty[2]), .rx_axis_tuser_mty3(mty[3]),
    .rx_axis_tuser_err0(err[0]), .rx_axis_tuser_err1(err[1]), .rx_axis_tuser_err2(err[2]), .rx_axis_tuser_err3(err[3]),
    .rx_axis_valid(valid),
    .axis0_out_tdata(o_d[0]), .axis1_out_tdata(o_d[1]), .axis2_out_tdata(o_d[2]), .axis3_out_tdata(o_d[3]),
    .axis0_out_tuser(o_u[0]), .axis1_out_tuser(o_u[1]), .axis2_out_tuser(o_u[2]), .axis3_out_tuser(o_u[3]),
    .axis0_out_tlast(o_l[0]), .axis1_out_tlast(o_l[1]), .axis2_out_tlast(o_l[2]), .axis3_out_tlast(o_l[3]),
    .axis0_out_tvalid(o_v[0]), .axis1_out_tvalid(o_v[1]), .axis2_out_tvalid(o_v[2]), .axis3_out_tvalid(o_v[3]),
    .overflow_count(ovf_cnt), .protocol_err_count(perr_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model state: segments of the open packet, predicted beats, FIFO occupancy.
  logic [127:0] pq [$];
  exp_t em_q [$];
  exp_t exp_q [$];
  bit   m_in = 1'b0;
  int   m_occ = 0, m_ovf = 0, m_perr = 0, last_out = 0;
  int   g_rem = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Close the open packet into one output beat: packet segments fill streams from 0 upward.
  function automatic void emit(input bit last, input bit e, input logic [3:0] m);
    exp_t x;
    x   = '0;
    x.l = last;
    for (int k = 0; k < 4; k++) begin
      if (k < pq.size()) begin
        x.d[k] = pq[k];
        x.u[k] = {e, 1'b0, (k == pq.size() - 1) ? m : 4'h0};
      end else begin
        x.u[k] = {e, 1'b1, 4'h0};
      end
    end
    em_q.push_back(x);
    pq.delete();
  endfunction

  task automatic model_reset();
    pq.delete(); em_q.delete(); exp_q.delete();
    m_in = 1'b0; m_occ = 0; m_ovf = 0; m_perr = 0; last_out = 0;
  endtask

  task automatic model_cycle();
    int pop, free, acc;
    em_q.delete();
    if (valid) begin
      for (int s = 0; s < 4; s++) begin
        if (ena[s]) begin
          bit take;
          take = 1'b1;
          if (sop[s]) begin
            if (m_in) begin
              emit(1'b1, 1'b1, 4'h0);
              m_perr++;
            end
            m_in = 1'b1;
            pq.delete();
          end else if (!m_in) begin
            m_perr++;
            take = 1'b0;
          end
          if (take) begin
            pq.push_back(td[s]);
            if (eop[s]) begin
              emit(1'b1, err[s] | sop[s], mty[s]);
              m_in = 1'b0;
            end else if (pq.size() == 4) begin
              emit(1'b0, 1'b0, 4'h0);
            end
          end
        end
      end
    end
    pop  = (m_occ > 0) ? 1 : 0;
    free = DEPTH - m_occ + pop;
    acc  = 0;
    foreach (em_q[i]) begin
      exp_t x;
      x = em_q[i];
      if (free > 0) begin
        x.c = (cyc + 1 > last_out + 1) ? cyc + 1 : last_out + 1;
        last_out = x.c;
        exp_q.push_back(x);
        free--;
        acc++;
      end else begin
        m_ovf++;
      end
    end
    m_occ = m_occ + acc - pop;
    if (m_ovf > SAT) m_ovf = SAT;
    if (m_perr > SAT) m_perr = SAT;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!resetn) model_reset();
    else model_cycle();
    @(negedge clk);
    chk("overflow_count", 128'(ovf_cnt), 128'(m_ovf));
    chk("protocol_err_count", 128'(perr_cnt), 128'(m_perr));
  endtask

  task automatic clr();
    valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ena[s] = 1'b0; sop[s] = 1'b0; eop[s] = 1'b0; err[s] = 1'b0; mty[s] = 4'h0; td[s] = '0;
    end
  endtask

  task automatic seg(input int s, input bit sp, input bit ep, input logic [3:0] m);
    valid = 1'b1;
    ena[s] = 1'b1; sop[s] = sp; eop[s] = ep; mty[s] = m; err[s] = 1'b0;
    td[s] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clr();
    step();
    resetn = 1'b1;
    g_rem = 0;
    mon_en = 1'b1;
    chk("reset_overflow_count", 128'(ovf_cnt), 128'd0);
    chk("reset_protocol_err_count", 128'(perr_cnt), 128'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_tvalid%0d", k), 128'(o_v[k]), 128'd0);
      chk($sformatf("reset_tlast%0d", k), 128'(o_l[k]), 128'd0);
      chk($sformatf("reset_tuser%0d", k), 128'(o_u[k]), 128'd0);
      chk($sformatf("reset_tdata%0d", k), o_d[k], 128'd0);
    end
  endtask

  task automatic drain();
    clr();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    chk("drain_beats_left", 128'(exp_q.size()), 128'd0);
  endtask

  // Random segment source; inject adds orphan segments, mid-packet sops and runt packets.
  task automatic gen(input int p_valid, input int p_ena, input bit inject, input int flen);
    valid = ($urandom_range(99) < p_valid);
    for (int s = 0; s < 4; s++) begin
      td[s] = {$urandom, $urandom, $urandom, $urandom};
      mty[s] = 4'($urandom);
      err[s] = ($urandom_range(7) == 0);
      ena[s] = 1'b0; sop[s] = 1'b0; eop[s] = 1'b0;
      if (!valid) begin
        ena[s] = 1'($urandom); sop[s] = 1'($urandom); eop[s] = 1'($urandom);
      end else if ($urandom_range(99) < p_ena) begin
        ena[s] = 1'b1;
        if (g_rem == 0) begin
          if (inject && $urandom_range(29) == 0) begin
            eop[s] = 1'($urandom);
          end else begin
            sop[s] = 1'b1;
            g_rem = (flen > 0) ? flen : $urandom_range(20, 4);
            if (inject && $urandom_range(24) == 0) g_rem = 1;
          end
        end else if (inject && $urandom_range(39) == 0) begin
          sop[s] = 1'b1;
          g_rem = $urandom_range(20, 4);
        end
        if (g_rem > 0) begin
          if (g_rem == 1) eop[s] = 1'b1;
          g_rem--;
        end
      end
    end
  endtask

  // Monitor: each output beat must match the head of the scoreboard in the predicted cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit want;
      exp_t x;
      while (exp_q.size() > 0 && exp_q[0].c < cyc) void'(exp_q.pop_front());
      want = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      for (int k = 0; k < 4; k++) chk($sformatf("tvalid%0d", k), 128'(o_v[k]), 128'(want));
      if (want) begin
        x = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("tdata%0d", k), o_d[k], x.d[k]);
          chk($sformatf("tuser%0d", k), 128'(o_u[k]), 128'(x.u[k]));
          chk($sformatf("tlast%0d", k), 128'(o_l[k]), 128'(x.l));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    do_reset();

    // Aligned 64B packet.
    clr(); seg(0, 1, 0, 0); seg(1, 0, 0, 0); seg(2, 0, 0, 0); seg(3, 0, 1, 0); step();
    drain();

    // Unaligned 100B packet starting in segment 2.
    clr(); seg(2, 1, 0, 0); seg(3, 0, 0, 0); step();
    clr(); for (int s = 0; s < 4; s++) seg(s, 0, 0, 0); step();
    clr(); seg(0, 0, 1, 4'd12); step();
    drain();

    // Abutting packets: 3 staged, P1 tail in seg0-1, P2 starts in seg2.
    clr(); for (int s = 0; s < 4; s++) seg(s, s == 0, 0, 0); step();
    clr(); seg(1, 0, 0, 0); seg(2, 0, 0, 0); seg(3, 0, 0, 0); step();
    clr(); seg(0, 0, 0, 0); seg(1, 0, 1, 4'd5); seg(2, 1, 0, 0); seg(3, 0, 0, 0); step();
    clr(); seg(0, 0, 0, 0); seg(1, 0, 1, 4'd3); step();
    drain();
    chk("abut_overflow_zero", 128'(ovf_cnt), 128'd0);

    // Framing errors.
    do_reset();
    clr(); seg(1, 0, 0, 0); step();
    chk("orphan_perr_1", 128'(perr_cnt), 128'd1);
    clr(); for (int s = 0; s < 4; s++) seg(s, s == 0, 0, 0); step();
    clr(); for (int s = 0; s < 4; s++) seg(s, s == 1, 0, 0); step();
    clr(); seg(0, 0, 0, 0); seg(1, 0, 1, 4'd7); step();
    drain();
    chk("sop_in_pkt_perr_2", 128'(perr_cnt), 128'd2);

    // Reset in the middle of a 10-beat packet.
    do_reset();
    for (int i = 0; i < 3; i++) begin gen(100, 100, 1'b0, 40); step(); end
    do_reset();
    for (int i = 0; i < 2; i++) begin gen(100, 100, 1'b0, 8); step(); end
    drain();

    // Overflow: back-to-back 5-segment packets, long enough to saturate the counter.
    do_reset();
    for (int i = 0; i < 120; i++) begin gen(100, 100, 1'b0, 5); step(); end
    drain();
    chk("overflow_saturated", 128'(ovf_cnt), 128'(SAT));

    // Random traffic with framing faults and occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      gen(85, 80, 1'b1, 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
